// File: rtl/lat_inhib_arb_pkg.sv
// Shared layer dimensions and FSM state type for the lateral-inhibition arbiter.
package lat_inhib_arb_pkg;

  localparam int N2 = 8;
  localparam int WP = 24;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_COMPARE = 2'd2,
    S_RESPOND = 2'd3
  } li_state_t;

  // Index width that stays legal for a single-neuron layer.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lat_inhib_arb_if.sv
// Neuron-side bundle of the lateral-inhibition arbiter: requests, potentials, spikes in; strobe and level out.
interface lat_inhib_arb_if
  import lat_inhib_arb_pkg::*;
#(
  parameter int N  = N2,
  parameter int W  = WP,
  parameter int IW = idx_w(N)
);

  logic           start_core_img;
  logic [N-1:0]   start_li;
  logic [N*W-1:0] potential;
  logic [N-1:0]   spike_op;
  logic           valid_li;
  logic [N-1:0]   won_lost;
  logic [IW-1:0]  winner_idx;
  logic           li;
  logic           busy;
  logic           li_overrun;

  modport slave (
    input  start_core_img, start_li, potential, spike_op,
    output valid_li, won_lost, winner_idx, li, busy, li_overrun
  );

  modport master (
    output start_core_img, start_li, potential, spike_op,
    input  valid_li, won_lost, winner_idx, li, busy, li_overrun
  );

endinterface

// File: rtl/lat_inhib_arb.sv
// Picks the max-potential requester and strobes a one-hot winner N cycles after the set closes.
// No backpressure: requests arriving during COMPARE/RESPOND are dropped and flagged in li_overrun.
module lat_inhib_arb
  import lat_inhib_arb_pkg::*;
#(
  parameter int N  = N2,
  parameter int W  = WP,
  parameter int TO = 255
) (
  input  logic             clk,
  input  logic             rst,
  lat_inhib_arb_if.slave   bus
);

  localparam int IW  = idx_w(N);
  localparam int TCW = $clog2(TO + 1);
  localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);
  localparam logic [TCW-1:0] TO_CNT   = TCW'(TO);

  li_state_t             r_state;
  logic [N-1:0]          r_seen;
  logic signed [W-1:0]   r_pot [N];
  logic [TCW-1:0]        r_tcnt;
  logic [IW-1:0]         r_idx;
  logic [IW-1:0]         r_best;
  logic signed [W-1:0]   r_best_pot;
  logic                  r_best_vld;
  logic                  r_valid;
  logic [N-1:0]          r_won;
  logic [IW-1:0]         r_win_idx;
  logic                  r_li;
  logic                  r_ovr;

  logic                  w_abort;
  logic                  w_accept;
  logic                  w_cap;
  logic [N-1:0]          w_seen_nxt;
  logic                  w_all_seen;
  logic signed [W-1:0]   w_cand;
  logic                  w_take;
  logic [IW-1:0]         w_best_nxt;
  logic signed [W-1:0]   w_best_pot_nxt;
  logic [N-1:0]          w_onehot;

  always_comb begin
    w_abort        = rst || bus.start_core_img;
    w_accept       = (r_state == S_IDLE) || (r_state == S_COLLECT);
    w_cap          = !w_abort && w_accept;
    w_seen_nxt     = r_seen | bus.start_li;
    w_all_seen     = &w_seen_nxt;
    w_cand         = r_pot[r_idx];
    // Strict greater-than keeps ties on the lowest index.
    w_take         = r_seen[r_idx] && (!r_best_vld || (w_cand > r_best_pot));
    w_best_nxt     = w_take ? r_idx : r_best;
    w_best_pot_nxt = w_take ? w_cand : r_best_pot;
    w_onehot             = '0;
    w_onehot[w_best_nxt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (w_cap && bus.start_li[i]) begin
        r_pot[i] <= bus.potential[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_abort) begin
      r_state    <= S_IDLE;
      r_seen     <= '0;
      r_tcnt     <= '0;
      r_idx      <= '0;
      r_best     <= '0;
      r_best_pot <= '0;
      r_best_vld <= 1'b0;
      r_valid    <= 1'b0;
      r_won      <= '0;
      r_win_idx  <= '0;
      r_li       <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_won   <= '0;
      if (|bus.spike_op) begin
        r_li <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (|bus.start_li) begin
            r_seen     <= w_seen_nxt;
            r_tcnt     <= '0;
            r_idx      <= '0;
            r_best_vld <= 1'b0;
            r_state    <= w_all_seen ? S_COMPARE : S_COLLECT;
          end
        end
        S_COLLECT: begin
          r_seen <= w_seen_nxt;
          r_tcnt <= r_tcnt + 1'b1;
          if (w_all_seen || (r_tcnt == TO_CNT)) begin
            r_idx      <= '0;
            r_best_vld <= 1'b0;
            r_state    <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (|bus.start_li) begin
            r_ovr <= 1'b1;
          end
          r_best     <= w_best_nxt;
          r_best_pot <= w_best_pot_nxt;
          r_best_vld <= r_best_vld || w_take;
          // The last scan step also loads the response so it is visible the next cycle.
          if (r_idx == LAST_IDX) begin
            r_valid   <= 1'b1;
            r_won     <= w_onehot;
            r_win_idx <= w_best_nxt;
            r_state   <= S_RESPOND;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_RESPOND: begin
          if (|bus.start_li) begin
            r_ovr <= 1'b1;
          end
          r_seen  <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.valid_li   = r_valid;
  assign bus.won_lost   = r_won;
  assign bus.winner_idx = r_win_idx;
  assign bus.li         = r_li;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.li_overrun = r_ovr;

endmodule
